// File: rtl/ravan_axi_initiator.sv
// RAVAN crypto engine initiator: runs one job through AW/W/B then AR/R,
// captures the engine result, and aborts any phase that stalls too long.
module ravan_axi_initiator #(
   parameter int DATA_W  = 64,
   parameter int KEY_W   = 512,
   parameter int ADDR_W  = 16,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] job_data,
   input  logic [KEY_W-1:0]  job_key,
   input  logic [ADDR_W-1:0] job_addr,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] result,
   output logic              sha_err,
   output logic [DATA_W-1:0] m_data,
   output logic [KEY_W-1:0]  m_key,
   output logic [ADDR_W-1:0] m_address,
   input  logic [DATA_W-1:0] s_data_out,
   input  logic              s_sha_error,
   output logic              awvalid,
   input  logic              awready,
   output logic              wvalid,
   input  logic              wready,
   input  logic              bvalid,
   output logic              bready,
   output logic              arvalid,
   input  logic              arready,
   input  logic              rvalid,
   output logic              rready
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_CAP
   } state_t;

   state_t            state_q;
   logic [7:0]        cnt_q;
   logic              busy_q, done_q, err_q, sha_q;
   logic              awvalid_q, wvalid_q, bready_q;
   logic              arvalid_q, rready_q;
   logic [DATA_W-1:0] result_q, mdata_q;
   logic [KEY_W-1:0]  mkey_q;
   logic [ADDR_W-1:0] maddr_q;

   logic phase_hs, waiting, to_hit;

   always_comb begin
      phase_hs = 1'b0;
      waiting  = 1'b1;
      unique case (state_q)
         S_AW:    phase_hs = awvalid_q & awready;
         S_W:     phase_hs = wvalid_q & wready;
         S_B:     phase_hs = bready_q & bvalid;
         S_AR:    phase_hs = arvalid_q & arready;
         S_R:     phase_hs = rready_q & rvalid;
         default: waiting  = 1'b0;
      endcase
      // A handshake on the deadline edge still wins over the abort.
      to_hit = waiting & ~phase_hs & (cnt_q == TO_LAST);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         sha_q     <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         result_q  <= '0;
         mdata_q   <= '0;
         mkey_q    <= '0;
         maddr_q   <= '0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         cnt_q  <= (waiting && !phase_hs) ? cnt_q + 8'd1 : 8'd0;
         if (to_hit) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            err_q     <= 1'b1;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            state_q   <= S_IDLE;
         end else begin
            unique case (state_q)
               S_IDLE: begin
                  if (start && !done_q) begin
                     mdata_q   <= job_data;
                     mkey_q    <= job_key;
                     maddr_q   <= job_addr;
                     awvalid_q <= 1'b1;
                     busy_q    <= 1'b1;
                     state_q   <= S_AW;
                  end
               end
               S_AW: begin
                  if (phase_hs) begin
                     awvalid_q <= 1'b0;
                     wvalid_q  <= 1'b1;
                     state_q   <= S_W;
                  end
               end
               S_W: begin
                  if (phase_hs) begin
                     wvalid_q <= 1'b0;
                     state_q  <= S_B;
                  end
               end
               S_B: begin
                  if (phase_hs) begin
                     bready_q  <= 1'b0;
                     arvalid_q <= 1'b1;
                     state_q   <= S_AR;
                  end else if (bvalid) begin
                     bready_q <= 1'b1;
                  end
               end
               S_AR: begin
                  if (phase_hs) begin
                     arvalid_q <= 1'b0;
                     state_q   <= S_R;
                  end
               end
               S_R: begin
                  if (phase_hs) begin
                     rready_q <= 1'b0;
                     state_q  <= S_CAP;
                  end else if (rvalid) begin
                     rready_q <= 1'b1;
                  end
               end
               S_CAP: begin
                  result_q <= s_data_out;
                  sha_q    <= s_sha_error;
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= S_IDLE;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign result    = result_q;
   assign sha_err   = sha_q;
   assign m_data    = mdata_q;
   assign m_key     = mkey_q;
   assign m_address = maddr_q;
   assign awvalid   = awvalid_q;
   assign wvalid    = wvalid_q;
   assign bready    = bready_q;
   assign arvalid   = arvalid_q;
   assign rready    = rready_q;

endmodule

// File: tb/tb_ravan_axi_initiator.sv
// Bench for ravan_axi_initiator: delay-programmable engine responder,
// job-level timing/result model feeding a scoreboard queue.
module tb_ravan_axi_initiator;

   localparam int TO = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [63:0]  job_data = '0;
   logic [511:0] job_key = '0;
   logic [15:0]  job_addr = '0;
   logic         busy, done, err, sha_err;
   logic [63:0]  result, m_data;
   logic [511:0] m_key;
   logic [15:0]  m_address;
   logic [63:0]  s_data_out = '0;
   logic         s_sha_error = 1'b0;
   logic         awvalid, wvalid, bready, arvalid, rready;
   logic         awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
   logic         arready = 1'b0, rvalid = 1'b0;

   always #5 clk = ~clk;

   ravan_axi_initiator #(
      .DATA_W(64), .KEY_W(512), .ADDR_W(16), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .job_data(job_data), .job_key(job_key), .job_addr(job_addr),
      .busy(busy), .done(done), .err(err),
      .result(result), .sha_err(sha_err),
      .m_data(m_data), .m_key(m_key), .m_address(m_address),
      .s_data_out(s_data_out), .s_sha_error(s_sha_error),
      .awvalid(awvalid), .awready(awready),
      .wvalid(wvalid), .wready(wready),
      .bvalid(bvalid), .bready(bready),
      .arvalid(arvalid), .arready(arready),
      .rvalid(rvalid), .rready(rready)
   );

   typedef struct {
      bit           is_err;
      int           at;
      logic [63:0]  res;
      bit           sha;
      logic [63:0]  data;
      logic [511:0] key;
      logic [15:0]  addr;
   } exp_t;

   exp_t        q[$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   logic [63:0] model_res = '0;
   bit          model_sha = 1'b0;
   int          aw_d = 0, w_d = 0, b_d = 0, ar_d = 0, r_d = 0;
   bit          eng_sha = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] eng_f(input logic [63:0] d,
                                         input logic [511:0] k,
                                         input logic [15:0] a);
      return {d[31:0], d[63:32]} ^ k[63:0] ^ k[511:448] ^ {4{a}};
   endfunction

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Engine responder: ready after N cycles of valid, response N cycles later
   initial begin
      bit awh, wh, bh, arh, rh, bp, rp;
      int awc, wc, arc, bc, rc;
      bp = 0; rp = 0; awc = 0; wc = 0; arc = 0; bc = 0; rc = 0;
      forever begin
         @(posedge clk);
         awh = awvalid && awready;
         wh  = wvalid && wready;
         bh  = bvalid && bready;
         arh = arvalid && arready;
         rh  = rvalid && rready;
         #1;
         if (!rst || !busy) begin
            awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
            bp = 0; rp = 0; awc = 0; wc = 0; arc = 0; bc = 0; rc = 0;
            s_data_out  = {$urandom, $urandom};
            s_sha_error = 1'($urandom);
         end else begin
            awready = awvalid && (awc >= aw_d);
            if (awvalid && !awready) awc++;
            wready = wvalid && (wc >= w_d);
            if (wvalid && !wready) wc++;
            arready = arvalid && (arc >= ar_d);
            if (arvalid && !arready) arc++;
            if (wh) begin bp = 1; bc = 0; end
            if (bh) begin bp = 0; bvalid = 0; end
            if (bp && !bvalid) begin
               if (bc >= b_d) bvalid = 1;
               else bc++;
            end
            if (arh) begin
               rp = 1; rc = 0;
               s_data_out = {$urandom, $urandom};
            end
            if (rh) begin
               rp = 0; rvalid = 0;
               s_data_out  = eng_f(m_data, m_key, m_address);
               s_sha_error = eng_sha;
            end
            if (rp && !rvalid) begin
               if (rc >= r_d) rvalid = 1;
               else rc++;
            end
         end
      end
   end

   always @(negedge clk) begin : mon
      exp_t e;
      if (rst && (done || err)) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse: done=%b err=%b, none expected",
                     done, err);
         end else begin
            e = q.pop_front();
            chk("kind_err", {63'd0, err}, {63'd0, e.is_err});
            chk("kind_done", {63'd0, done}, {63'd0, !e.is_err});
            chk("cycle", 64'(cyc), 64'(e.at));
            chk("result", result, e.res);
            chk("sha_err", {63'd0, sha_err}, {63'd0, e.sha});
            chk("m_data", m_data, e.data);
            chk("m_key_lo", m_key[63:0], e.key[63:0]);
            chk("m_key_hi", m_key[511:448], e.key[511:448]);
            chk("m_address", {48'd0, m_address}, {48'd0, e.addr});
            chk("busy_low", {63'd0, busy}, 64'd0);
            if (err)
               chk("hs_idle", {59'd0, awvalid, wvalid, bready, arvalid, rready}, 64'd0);
         end
      end
   end

   task automatic do_reset();
      rst = 0;
      @(posedge clk); #1;
      rst = 1;
      model_res = '0;
      model_sha = 0;
   endtask

   task automatic set_job(input logic [63:0] d, input bit sha);
      job_data = d;
      job_addr = 16'($urandom);
      for (int i = 0; i < 16; i++) job_key[i*32 +: 32] = $urandom;
      eng_sha = sha;
   endtask

   task automatic scramble();
      job_data = {$urandom, $urandom};
      job_addr = 16'($urandom);
      for (int i = 0; i < 16; i++) job_key[i*32 +: 32] = $urandom;
   endtask

   // Job-level model: each phase costs (delay+1), or (delay+2) where the
   // initiator must first see the engine's valid; CAP adds one cycle.
   task automatic push_model(input int acc, output int at_out);
      exp_t e;
      int   dur[5];
      int   t;
      dur = '{aw_d + 1, w_d + 1, b_d + 2, ar_d + 1, r_d + 2};
      e.is_err = 0;
      e.at = 0;
      t = 0;
      for (int p = 0; p < 5; p++) begin
         if (!e.is_err) begin
            if (dur[p] > TO) begin
               e.is_err = 1;
               e.at = acc + t + TO;
            end else begin
               t += dur[p];
            end
         end
      end
      if (!e.is_err) begin
         e.at = acc + t + 1;
         model_res = eng_f(job_data, job_key, job_addr);
         model_sha = eng_sha;
      end
      e.res = model_res;
      e.sha = model_sha;
      e.data = job_data;
      e.key = job_key;
      e.addr = job_addr;
      q.push_back(e);
      at_out = e.at;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (q.size() != 0 && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL %s_timeout: %0d results outstanding, want 0", name, q.size());
         q.delete();
         do_reset();
      end
   endtask

   task automatic run_job(input int a, input int w, input int b,
                          input int ar, input int r,
                          input logic [63:0] d, input bit sha);
      int at;
      aw_d = a; w_d = w; b_d = b; ar_d = ar; r_d = r;
      set_job(d, sha);
      start = 1;
      push_model(cyc + 1, at);
      @(posedge clk); #1;
      start = 0;
      scramble();
      wait_drain("job");
   endtask

   function automatic int rd();
      if ($urandom_range(0, 7) == 0) return int'($urandom_range(13, 17));
      return int'($urandom_range(0, 3));
   endfunction

   initial begin
      int at1, at2, n;
      @(posedge clk); #1;
      chk("rst_ctrl", {56'd0, busy, done, err, awvalid, wvalid, bready,
                       arvalid, rready}, 64'd0);
      chk("rst_result", result, 64'd0);
      chk("rst_sha", {63'd0, sha_err}, 64'd0);
      chk("rst_m_data", m_data, 64'd0);
      chk("rst_m_key", {63'd0, |m_key}, 64'd0);
      chk("rst_m_addr", {48'd0, m_address}, 64'd0);
      rst = 1;
      @(posedge clk); #1;

      run_job(0, 0, 0, 0, 0, 64'h0123_4567_89AB_CDEF, 0);
      run_job(5, 0, 0, 0, 0, {$urandom, $urandom}, 1);
      run_job(0, 0, 0, 0, 0, {$urandom, $urandom}, 0);
      run_job(0, 0, 1000, 0, 0, {$urandom, $urandom}, 1);
      run_job(15, 0, 0, 0, 0, {$urandom, $urandom}, 1);
      run_job(16, 0, 0, 0, 0, {$urandom, $urandom}, 0);
      run_job(0, 15, 0, 0, 0, {$urandom, $urandom}, 0);
      run_job(0, 0, 14, 0, 0, {$urandom, $urandom}, 0);
      run_job(0, 0, 15, 0, 0, {$urandom, $urandom}, 1);
      run_job(0, 0, 0, 16, 0, {$urandom, $urandom}, 1);
      run_job(0, 0, 0, 0, 14, {$urandom, $urandom}, 1);
      run_job(0, 0, 0, 0, 15, {$urandom, $urandom}, 0);

      // start held high across two back-to-back jobs
      aw_d = 0; w_d = 0; b_d = 0; ar_d = 0; r_d = 0;
      set_job({$urandom, $urandom}, 1);
      start = 1;
      push_model(cyc + 1, at1);
      push_model(at1 + 2, at2);
      n = 0;
      while (cyc < at1 + 2 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      start = 0;
      wait_drain("held_start");
      repeat (12) @(posedge clk);
      #1;

      // reset while the engine is presenting read data
      aw_d = 0; w_d = 0; b_d = 0; ar_d = 0; r_d = 3;
      set_job({$urandom, $urandom}, 1);
      start = 1;
      push_model(cyc + 1, at1);
      @(posedge clk); #1;
      start = 0;
      n = 0;
      while (!(rvalid && busy) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("saw_rvalid", {63'd0, rvalid && busy}, 64'd1);
      rst = 0;
      #1;
      chk("rst_mid_ctrl", {56'd0, busy, done, err, awvalid, wvalid, bready,
                           arvalid, rready}, 64'd0);
      chk("rst_mid_result", result, 64'd0);
      chk("rst_mid_m_data", m_data, 64'd0);
      chk("rst_mid_m_addr", {48'd0, m_address}, 64'd0);
      q.delete();
      model_res = '0;
      model_sha = 0;
      @(posedge clk); #1;
      rst = 1;
      repeat (20) @(posedge clk);
      #1;

      for (int j = 0; j < 30; j++) begin
         run_job(rd(), rd(), rd(), rd(), rd(), {$urandom, $urandom},
                 1'($urandom));
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
